// File: rtl/combat_resolver_if.sv
// Unit-side bus between the combat resolver (master) and the two front units (slave).
interface combat_resolver_if #(
   parameter int unsigned POS_W = 9,
   parameter int unsigned DMG_W = 8
);
   logic [POS_W-1:0] ally_pos;
   logic [DMG_W-1:0] ally_dmg;
   logic             ally_dead;
   logic [POS_W-1:0] enemy_pos;
   logic [DMG_W-1:0] enemy_dmg;
   logic             enemy_dead;

   logic             ally_move_scen;
   logic             ally_damage_scen;
   logic [DMG_W-1:0] ally_damage_in;
   logic             enemy_move_scen;
   logic             enemy_damage_scen;
   logic [DMG_W-1:0] enemy_damage_in;

   modport master (
      input  ally_pos, ally_dmg, ally_dead, enemy_pos, enemy_dmg, enemy_dead,
      output ally_move_scen, ally_damage_scen, ally_damage_in,
             enemy_move_scen, enemy_damage_scen, enemy_damage_in
   );

   modport slave (
      output ally_pos, ally_dmg, ally_dead, enemy_pos, enemy_dmg, enemy_dead,
      input  ally_move_scen, ally_damage_scen, ally_damage_in,
             enemy_move_scen, enemy_damage_scen, enemy_damage_in
   );
endinterface

// File: rtl/combat_resolver.sv
// Lane-combat arbiter between the front ally and front enemy unit.
// Per game tick: IDLE -> EVAL (sample units, decide) -> ISSUE (one-cycle strobes) -> IDLE.
// Optional feature macro COMBAT_CRIT_EN: every 8th exchange delivered by a side deals
// doubled (saturating) damage.
module combat_resolver #(
   parameter int unsigned POS_W         = 9,
   parameter int unsigned DMG_W         = 8,
   parameter int unsigned RANGE         = 4,
   parameter int unsigned ATTACK_PERIOD = 4,
   parameter int unsigned LANE_END      = 511
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_tick,
   combat_resolver_if.master  m_unit,
   output logic               o_ally_breach,
   output logic               o_enemy_breach,
   output logic               o_overrun,
   output logic               o_busy
);
   localparam int unsigned CD_W = (ATTACK_PERIOD > 1) ? $clog2(ATTACK_PERIOD) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_EVAL  = 2'd1;
   localparam logic [1:0] S_ISSUE = 2'd2;

   logic [1:0]       r_state, w_state_nxt;
   logic             r_busy;
   logic [CD_W-1:0]  r_cd;
   logic             r_ally_move, r_enemy_move;
   logic             r_ally_dscen, r_enemy_dscen;
   logic [DMG_W-1:0] r_ally_din, r_enemy_din;
   logic             r_ally_breach, r_enemy_breach, r_overrun;

   logic [POS_W-1:0] w_diff;
   logic             w_contact, w_ally_goal, w_enemy_goal, w_suppress;
   logic             w_exch_go, w_ally_move, w_enemy_move;
   logic [DMG_W-1:0] w_to_ally, w_to_enemy;

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_tick) w_state_nxt = S_EVAL;
         S_EVAL:  w_state_nxt = S_ISSUE;
         S_ISSUE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register and busy flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
      end
   end

   // Engagement decision from the unit inputs sampled during EVAL
   always_comb begin
      w_diff       = POS_W'(m_unit.ally_pos - m_unit.enemy_pos);
      // an ally that has slipped below the enemy still counts as contact (no pass-through)
      w_contact    = !m_unit.ally_dead && !m_unit.enemy_dead &&
                     ((m_unit.ally_pos < m_unit.enemy_pos) || (w_diff <= POS_W'(RANGE)));
      w_ally_goal  = !w_contact && !m_unit.ally_dead  && (m_unit.ally_pos == '0);
      w_enemy_goal = !w_contact && !m_unit.enemy_dead && (m_unit.enemy_pos == POS_W'(LANE_END));
      // a breach silences the lane, including the tick on which it is detected
      w_suppress   = r_ally_breach || r_enemy_breach || w_ally_goal || w_enemy_goal;
      w_exch_go    = w_contact && (r_cd == '0) && !w_suppress;
      w_ally_move  = !w_contact && !m_unit.ally_dead  && !w_suppress;
      w_enemy_move = !w_contact && !m_unit.enemy_dead && !w_suppress;
   end

`ifdef COMBAT_CRIT_EN
   logic [2:0] r_ally_crit, r_enemy_crit;

   function automatic logic [DMG_W-1:0] f_double_sat(input logic [DMG_W-1:0] d);
      logic [DMG_W:0] dbl;
      dbl = {d, 1'b0};
      return dbl[DMG_W] ? '1 : dbl[DMG_W-1:0];
   endfunction

   // Per-side exchange counters; counter value 7 marks the 8th delivered exchange
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ally_crit  <= 3'd0;
         r_enemy_crit <= 3'd0;
      end else if (r_state == S_EVAL && w_exch_go) begin
         r_ally_crit  <= r_ally_crit + 3'd1;
         r_enemy_crit <= r_enemy_crit + 3'd1;
      end
   end

   // Damage dealt by each side, doubled on its critical exchange
   always_comb begin
      w_to_enemy = (r_ally_crit  == 3'd7) ? f_double_sat(m_unit.ally_dmg)  : m_unit.ally_dmg;
      w_to_ally  = (r_enemy_crit == 3'd7) ? f_double_sat(m_unit.enemy_dmg) : m_unit.enemy_dmg;
   end
`else
   // Damage passes straight through
   always_comb begin
      w_to_enemy = m_unit.ally_dmg;
      w_to_ally  = m_unit.enemy_dmg;
   end
`endif

   // Strobe, cooldown and sticky-flag registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ally_move    <= 1'b0;
         r_enemy_move   <= 1'b0;
         r_ally_dscen   <= 1'b0;
         r_enemy_dscen  <= 1'b0;
         r_ally_din     <= '0;
         r_enemy_din    <= '0;
         r_cd           <= '0;
         r_ally_breach  <= 1'b0;
         r_enemy_breach <= 1'b0;
         r_overrun      <= 1'b0;
      end else begin
         r_ally_move   <= 1'b0;
         r_enemy_move  <= 1'b0;
         r_ally_dscen  <= 1'b0;
         r_enemy_dscen <= 1'b0;
         r_ally_din    <= '0;
         r_enemy_din   <= '0;
         if (r_state == S_EVAL) begin
            r_ally_move    <= w_ally_move;
            r_enemy_move   <= w_enemy_move;
            r_ally_dscen   <= w_exch_go;
            r_enemy_dscen  <= w_exch_go;
            r_ally_din     <= w_exch_go ? w_to_ally  : '0;
            r_enemy_din    <= w_exch_go ? w_to_enemy : '0;
            r_ally_breach  <= r_ally_breach  | w_enemy_goal;
            r_enemy_breach <= r_enemy_breach | w_ally_goal;
            if (!w_contact)
               r_cd <= '0;
            else if (r_cd == CD_W'(ATTACK_PERIOD - 1))
               r_cd <= '0;
            else
               r_cd <= r_cd + CD_W'(1);
         end
         if (i_tick && r_state != S_IDLE)
            r_overrun <= 1'b1;
      end
   end

   assign m_unit.ally_move_scen    = r_ally_move;
   assign m_unit.enemy_move_scen   = r_enemy_move;
   assign m_unit.ally_damage_scen  = r_ally_dscen;
   assign m_unit.enemy_damage_scen = r_enemy_dscen;
   assign m_unit.ally_damage_in    = r_ally_din;
   assign m_unit.enemy_damage_in   = r_enemy_din;
   assign o_ally_breach            = r_ally_breach;
   assign o_enemy_breach           = r_enemy_breach;
   assign o_overrun                = r_overrun;
   assign o_busy                   = r_busy;
endmodule

// File: doc/combat_resolver.md
# combat_resolver

Lane-combat arbiter between the front ally unit and the front enemy unit. On every game tick it compares the two unit positions, then issues move or damage strobes and damage values to each unit. It is the controlling end of the unit interface: it produces each unit's `move_scen`, `damage_scen` and `damage_in`, and consumes each unit's `position`, `damage_out` and `dead`. Enemies spawn at position 0 and advance upward; allies spawn at `LANE_END` and advance downward.

## Interface
- `POS_W`, 9: position width.
- `DMG_W`, 8: damage/power width.
- `RANGE`, 4: contact distance; units fight when `ally_pos - enemy_pos <= RANGE`.
- `ATTACK_PERIOD`, 4: ticks in contact per attack exchange, minimum 1.
- `LANE_END`, 511: ally base position and enemy goal.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `tick`  in  1  one-`clk` game-tick pulse, synchronous to `clk`.
- `ally_pos`  in  POS_W  front ally position.
- `ally_dmg`  in  DMG_W  ally `damage_out`.
- `ally_dead`  in  1  ally `dead`.
- `enemy_pos`, `enemy_dmg`, `enemy_dead`: same meaning for the enemy unit.
- `ally_move_scen`  out  1  one-cycle move strobe to the ally.
- `ally_damage_scen`  out  1  one-cycle damage strobe to the ally.
- `ally_damage_in`  out  DMG_W  damage applied to the ally.
- `enemy_move_scen`, `enemy_damage_scen`, `enemy_damage_in`: same for the enemy unit.
- `ally_breach`  out  1  sticky; the enemy reached `LANE_END`.
- `enemy_breach`  out  1  sticky; the ally reached 0.
- `overrun`  out  1  sticky; a tick arrived while the block was not in IDLE.
- `busy`  out  1  high in EVAL and ISSUE.

## Operation
- State machine, 3 states:
  - IDLE → EVAL on `tick`.
  - EVAL → ISSUE unconditionally.
  - ISSUE → IDLE unconditionally.
- EVAL latches all inputs and computes:
  - `contact = !ally_dead && !enemy_dead && ally_pos >= enemy_pos && (ally_pos - enemy_pos) <= RANGE`.
  - `ally_pos < enemy_pos` counts as contact, to prevent pass-through.
- Contact handling uses a cooldown counter `cd`, range 0..ATTACK_PERIOD-1:
  - On a contact tick with `cd == 0`: exchange, meaning both `damage_scen` pulse. `ally_damage_in` = latched `enemy_dmg`; `enemy_damage_in` = latched `ally_dmg`. The exchange is mutual in the same cycle.
  - On any contact tick, `cd` increments and wraps to 0 after `ATTACK_PERIOD-1`.
  - On contact ticks with `cd != 0`: no strobes.
  - On a non-contact tick, `cd` resets to 0, so the first contact tick always exchanges.
- Non-contact handling:
  - Each non-dead unit gets `move_scen` unless it sits at its goal.
  - Enemy at `enemy_pos == LANE_END`: `ally_breach` sets and no move is issued.
  - Ally at `ally_pos == 0`: `enemy_breach` sets and no move is issued.
- Dead units receive no strobes.
- `damage_in` outputs are 0 whenever the matching `damage_scen` is 0.
- After either breach flag sets, all strobes are suppressed until reset.

## Timing
- Reset values: all strobes 0, `damage_in` 0, all flags 0, `busy` 0, state IDLE, `cd` 0.
- Latency: `tick` at cycle T, EVAL at T+1, strobes and `damage_in` valid for exactly cycle T+2, back in IDLE at T+3.
- Input changes after EVAL do not affect the strobes issued in ISSUE.
- A `tick` at T+1 or T+2 is dropped and sets `overrun`. A `tick` at T+3 is accepted.
- Reset mid-operation aborts the cycle immediately; no strobe is emitted after reset is asserted.

## Configuration
- `COMBAT_CRIT_EN` defined:
  - Each side keeps a 3-bit exchange counter.
  - Every 8th exchange delivered by a side applies doubled damage, saturating at 2^DMG_W-1.
  - Counters reset with `reset`.
- `COMBAT_CRIT_EN` undefined: damage is passed through unmodified and no counters exist.

## Test plan
- `ally_pos=100`, `enemy_pos=50`, both alive, one tick → at T+2 both `move_scen`=1, no damage strobes, `busy`=1 at T+1 and T+2.
- `ally_pos=54`, `enemy_pos=50`, `ally_dmg=16`, `enemy_dmg=32`, `ATTACK_PERIOD=4`, 8 ticks → exchanges on ticks 1 and 5 only, with `ally_damage_in=32` and `enemy_damage_in=16`.
- `enemy_pos=511`, `ally_dead=1`, one tick → `ally_breach`=1, no strobes; it stays set and all later strobes stay 0 until reset.
- Tick, then a second tick one cycle later → `overrun`=1, exactly one set of strobes.
- Reset asserted at T+1 after a contact tick → no strobes at T+2, all outputs 0.
- With `COMBAT_CRIT_EN`, contact with `ally_dmg=200` over 8 exchanges → the 8th `enemy_damage_in`=255; without the macro it is 200.
